// File: rtl/fetch2_bundle_queue_if.sv
// Bundle-queue bus: fs1->fs2 producer side in, Fetch2/decode consumer side out.
// Signal suffixes are relative to the queue (_i = into queue, _o = out of queue).
// slave modport is the queue itself, master modport is the surrounding pipeline.
interface fetch2_bundle_queue_if #(
  parameter int FETCH_WIDTH = 4,
  parameter int PKT_W       = 64,
  parameter int CNT_LOG     = 10,
  parameter int DEPTH       = 4
);
  localparam int LW = $clog2(FETCH_WIDTH) + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  // producer side (fs1->fs2 pipeline register)
  logic                                   fs1Ready_i;
  logic [FETCH_WIDTH-1:0][PKT_W-1:0]      fs2Packet_i;
  logic [FETCH_WIDTH-1:0][1:0]            predCounter_i;
  logic [FETCH_WIDTH-1:0][CNT_LOG-1:0]    predIndex_i;
  logic                                   stall_o;

  // consumer side (Fetch2/decode)
  logic                                   ready_i;
  logic                                   bundleValid_o;
  logic [FETCH_WIDTH-1:0][PKT_W-1:0]      fs2Packet_o;
  logic [FETCH_WIDTH-1:0][1:0]            predCounter_o;
  logic [FETCH_WIDTH-1:0][CNT_LOG-1:0]    predIndex_o;
  logic [LW-1:0]                          laneCount_o;
  logic [CW-1:0]                          count_o;

  modport slave (
    input  fs1Ready_i, fs2Packet_i, predCounter_i, predIndex_i, ready_i,
    output stall_o, bundleValid_o, fs2Packet_o, predCounter_o, predIndex_o,
    output laneCount_o, count_o
  );

  modport master (
    output fs1Ready_i, fs2Packet_i, predCounter_i, predIndex_i, ready_i,
    input  stall_o, bundleValid_o, fs2Packet_o, predCounter_o, predIndex_o,
    input  laneCount_o, count_o
  );
endinterface

// File: rtl/fetch2_bundle_queue.sv
// Fetch1/Fetch2 receive-side bundle buffer: DEPTH-entry circular queue of fetch bundles.
// Latency: 1 cycle enqueue-to-head (0 when empty with FETCH2_QUEUE_BYPASS_EN defined).
// Backpressure: stall_o = registered full flag; upstream register holds while it is set.
module fetch2_bundle_queue #(
  parameter int FETCH_WIDTH = 4,
  parameter int PKT_W       = 64,
  parameter int CNT_LOG     = 10,
  parameter int DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  fetch2_bundle_queue_if.slave  q_if
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(FETCH_WIDTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef logic [FETCH_WIDTH-1:0][PKT_W-1:0]   pkt_vec_t;
  typedef logic [FETCH_WIDTH-1:0][1:0]         cnt_vec_t;
  typedef logic [FETCH_WIDTH-1:0][CNT_LOG-1:0] idx_vec_t;

  typedef struct packed {
    pkt_vec_t pkt;
    cnt_vec_t cnt;
    idx_vec_t idx;
  } bundle_t;

  // Entry storage is never cleared: count/pointers alone define what is live.
  bundle_t        mem_q [DEPTH];

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q,  count_d;

  bundle_t        in_bundle;
  bundle_t        head_bundle;
  logic           clear;
  logic           empty;
  logic           full;
  logic           enq;
  logic           deq;
  logic           head_vld;
  logic [LW-1:0]  lane_cnt;

  assign in_bundle = '{pkt: q_if.fs2Packet_i,
                       cnt: q_if.predCounter_i,
                       idx: q_if.predIndex_i};

  // Flush and reset share the same effect; both override any same-cycle enq/deq.
  assign clear = reset | flush_i;
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Storage dequeue only ever pops a stored entry, never a bypassed bundle.
  assign deq = ~empty & q_if.ready_i;

`ifdef FETCH2_QUEUE_BYPASS_EN
  logic byp_show;
  logic byp_take;

  // An empty queue forwards the incoming bundle straight to the head; if the
  // consumer takes it the same cycle, it never touches storage.
  assign byp_show = empty & q_if.fs1Ready_i & ~clear;
  assign byp_take = byp_show & q_if.ready_i;
  assign head_vld = ~empty | byp_show;
  assign enq      = q_if.fs1Ready_i & ~full & ~byp_take;

  // Head select: bypassed input, stored entry, or zeros when nothing is valid.
  always_comb begin
    head_bundle = '0;
    if (byp_show) begin
      head_bundle = in_bundle;
    end else if (!empty) begin
      head_bundle = mem_q[rd_ptr_q];
    end
  end
`else
  assign head_vld = ~empty;
  assign enq      = q_if.fs1Ready_i & ~full;

  // Head select: oldest stored entry, zeros when empty.
  always_comb begin
    head_bundle = '0;
    if (!empty) begin
      head_bundle = mem_q[rd_ptr_q];
    end
  end
`endif

  // Pointer/occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Entry write; a flushed-cycle bundle is dropped rather than stored.
  always_ff @(posedge clk) begin
    if (enq && !clear) begin
      mem_q[wr_ptr_q] <= in_bundle;
    end
  end

  // Count of valid lanes (bit 0 of each packet) in the head bundle.
  always_comb begin
    lane_cnt = '0;
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      lane_cnt = lane_cnt + LW'(head_bundle.pkt[l][0]);
    end
  end

  assign q_if.stall_o       = full;
  assign q_if.bundleValid_o = head_vld;
  assign q_if.fs2Packet_o   = head_bundle.pkt;
  assign q_if.predCounter_o = head_bundle.cnt;
  assign q_if.predIndex_o   = head_bundle.idx;
  assign q_if.laneCount_o   = lane_cnt;
  assign q_if.count_o       = count_q;
endmodule
